// File: rtl/i2s_pkg.sv
// Shared sample and stereo-pair types for the I2S transmitter slice.
package i2s_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample stream and I2S pin bundle; master = transmitter side, slave = feeder/observer.
interface i2s_master_tx_if
    import i2s_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              sclk;
    logic              ws;
    logic              sd;
    logic              underrun;
    logic              frame_start;

    modport master (
        input  s_valid, s_left, s_right,
        output s_ready, sclk, ws, sd, underrun, frame_start
    );

    modport slave (
        output s_valid, s_left, s_right,
        input  s_ready, sclk, ws, sd, underrun, frame_start
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: registered sclk plus single-cycle strobes on the clk cycle before each edge.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic fall,
    output logic rise
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          toggle;

    assign toggle = en && (div_cnt == LAST);
    assign fall   = toggle && sclk;
    assign rise   = toggle && !sclk;

    // Disabling parks sclk low so the first edge after enable is always a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (toggle) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// Philips I2S master transmitter with a one-pair holding register.
// Define I2S_TX_HOLD_LAST_EN to repeat the last pair on underrun instead of sending zeros.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W  = SAMPLE_W,
    parameter int SLOT_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    i2s_master_tx_if.master        bus
);

    localparam int            BW        = $clog2(2 * SLOT_W);
    localparam logic [BW-1:0] LAST_B    = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] WS_RISE   = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] LEFT_END  = BW'(DATA_W);
    localparam logic [BW-1:0] RIGHT_BEG = BW'(SLOT_W);
    localparam logic [BW-1:0] RIGHT_END = BW'(SLOT_W + DATA_W);

    logic              fall;
    logic              rise_unused;
    logic [BW-1:0]     b;
    logic              load;
    logic              wr;
    logic              hold_empty;
    logic [DATA_W-1:0] hold_left;
    logic [DATA_W-1:0] hold_right;
    logic [DATA_W-1:0] src_left;
    logic [DATA_W-1:0] src_right;
    logic [DATA_W-1:0] left_sh;
    logic [DATA_W-1:0] right_sh;
`ifdef I2S_TX_HOLD_LAST_EN
    logic [DATA_W-1:0] last_left;
    logic [DATA_W-1:0] last_right;
`endif

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sclk  (bus.sclk),
        .fall  (fall),
        .rise  (rise_unused)
    );

    assign load        = fall && (b == '0);
    assign wr          = bus.s_valid && hold_empty;
    assign bus.s_ready = hold_empty;

    always_comb begin
        src_left  = hold_left;
        src_right = hold_right;
        if (hold_empty) begin
`ifdef I2S_TX_HOLD_LAST_EN
            src_left  = last_left;
            src_right = last_right;
`else
            src_left  = '0;
            src_right = '0;
`endif
        end
    end

    // A write landing on the load cycle is kept for the next frame; this frame underruns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_empty <= 1'b1;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (wr) begin
            hold_empty <= 1'b0;
            hold_left  <= bus.s_left;
            hold_right <= bus.s_right;
        end else if (load) begin
            hold_empty <= 1'b1;
        end
    end

`ifdef I2S_TX_HOLD_LAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (en && load) begin
            last_left  <= src_left;
            last_right <= src_right;
        end
    end
`endif

    // ws and sd change only on falling sclk so the receiver can sample on the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b               <= '0;
            bus.ws          <= 1'b0;
            bus.sd          <= 1'b0;
            bus.underrun    <= 1'b0;
            bus.frame_start <= 1'b0;
            left_sh         <= '0;
            right_sh        <= '0;
        end else begin
            bus.underrun    <= 1'b0;
            bus.frame_start <= 1'b0;
            if (!en) begin
                b      <= '0;
                bus.ws <= 1'b0;
                bus.sd <= 1'b0;
            end else if (fall) begin
                b      <= (b == LAST_B) ? '0 : b + BW'(1);
                bus.ws <= (b >= WS_RISE) && (b != LAST_B);
                if (load) begin
                    bus.frame_start <= 1'b1;
                    bus.underrun    <= hold_empty;
                    bus.sd          <= src_left[DATA_W-1];
                    left_sh         <= src_left << 1;
                    right_sh        <= src_right;
                end else if (b < LEFT_END) begin
                    bus.sd  <= left_sh[DATA_W-1];
                    left_sh <= left_sh << 1;
                end else if ((b >= RIGHT_BEG) && (b < RIGHT_END)) begin
                    bus.sd   <= right_sh[DATA_W-1];
                    right_sh <= right_sh << 1;
                end else begin
                    bus.sd <= 1'b0;
                end
            end
        end
    end

endmodule
